// File: rtl/ysyx_pkg.sv
// Shared ysyx core types and constants.
// Used by fetch, decode and writeback.
package ysyx_pkg;

  typedef enum logic [1:0] {
    S_REQ,
    S_WAIT,
    S_DELIVER,
    S_WAITPC
  } ifu_state_t;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;
  localparam logic [31:0] RESET_PC = 32'h8000_0000;

endpackage

// File: rtl/ysyx_ifu_fetch_if.sv
// Fetch unit bundle: imem request/response,
// decode handshake, next-pc and redirect.
interface ysyx_ifu_fetch_if;

  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        imem_rsp_err;
  logic        inst_valid;
  logic        inst_ready;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_err;
  logic        pc_upd_valid;
  logic [31:0] pc_upd;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  modport master (
    output imem_req_valid,
    output imem_req_addr,
    input  imem_req_ready,
    input  imem_rsp_valid,
    input  imem_rsp_data,
    input  imem_rsp_err,
    output inst_valid,
    output inst,
    output inst_pc,
    output inst_err,
    input  inst_ready,
    input  pc_upd_valid,
    input  pc_upd,
    input  redirect_valid,
    input  redirect_pc
  );

  modport slave (
    input  imem_req_valid,
    input  imem_req_addr,
    output imem_req_ready,
    output imem_rsp_valid,
    output imem_rsp_data,
    output imem_rsp_err,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  inst_err,
    output inst_ready,
    output pc_upd_valid,
    output pc_upd,
    output redirect_valid,
    output redirect_pc
  );

endinterface

// File: rtl/ysyx_ifu_fetch.sv
// Multi-cycle instruction fetch: owns the PC,
// one imem transaction in flight at a time.
module ysyx_ifu_fetch
  import ysyx_pkg::*;
#(
  parameter logic [31:0] RESET_PC = ysyx_pkg::RESET_PC,
  parameter logic [31:0] NOP_INST = ysyx_pkg::NOP_INST
) (
  input  logic clk,
  input  logic rst_n,
  ysyx_ifu_fetch_if.master bus
);

  ifu_state_t  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] inst_pc_q, inst_pc_d;
  logic        inst_err_q, inst_err_d;
  logic        drop_q, drop_d;
  logic        req_valid_q, req_valid_d;
  logic        inst_valid_q, inst_valid_d;

  logic req_fire;
  logic misalign;

  assign req_fire = req_valid_q & bus.imem_req_ready;
  assign misalign = |pc_q[1:0];

  always_comb begin
    state_d    = state_q;
    pc_d       = pc_q;
    inst_d     = inst_q;
    inst_pc_d  = inst_pc_q;
    inst_err_d = inst_err_q;
    drop_d     = drop_q;

    if (drop_q && bus.imem_rsp_valid)
      drop_d = 1'b0;

    unique case (state_q)
      S_REQ: begin
        if (misalign) begin
          inst_d     = NOP_INST;
          inst_err_d = 1'b1;
          inst_pc_d  = pc_q;
          state_d    = S_DELIVER;
        end else if (req_fire) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (bus.imem_rsp_valid) begin
          inst_d     = bus.imem_rsp_err ?
                       NOP_INST : bus.imem_rsp_data;
          inst_err_d = bus.imem_rsp_err;
          inst_pc_d  = pc_q;
          state_d    = S_DELIVER;
        end
      end
      S_DELIVER: begin
        if (inst_valid_q && bus.inst_ready)
          state_d = S_WAITPC;
      end
      S_WAITPC: begin
        if (bus.pc_upd_valid) begin
          pc_d    = bus.pc_upd;
          state_d = S_REQ;
        end
      end
    endcase

    // A response landing with the redirect closes the
    // transaction, so only a still-open one needs dropping.
    if (bus.redirect_valid) begin
      pc_d    = bus.redirect_pc;
      state_d = S_REQ;
      if ((state_q == S_WAIT && !bus.imem_rsp_valid) ||
          (state_q == S_REQ && req_fire))
        drop_d = 1'b1;
    end

    req_valid_d  = (state_d == S_REQ) & ~drop_d &
                   ~(|pc_d[1:0]);
    inst_valid_d = (state_d == S_DELIVER);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_REQ;
      pc_q         <= RESET_PC;
      inst_q       <= NOP_INST;
      inst_pc_q    <= RESET_PC;
      inst_err_q   <= 1'b0;
      drop_q       <= 1'b0;
      req_valid_q  <= 1'b0;
      inst_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      inst_q       <= inst_d;
      inst_pc_q    <= inst_pc_d;
      inst_err_q   <= inst_err_d;
      drop_q       <= drop_d;
      req_valid_q  <= req_valid_d;
      inst_valid_q <= inst_valid_d;
    end
  end

  assign bus.imem_req_valid = req_valid_q;
  assign bus.imem_req_addr  = pc_q;
  assign bus.inst_valid     = inst_valid_q;
  assign bus.inst           = inst_q;
  assign bus.inst_pc        = inst_pc_q;
  assign bus.inst_err       = inst_err_q;

endmodule

// File: tb/tb_ysyx_ifu_fetch.sv
// Scoreboard bench for ysyx_ifu_fetch: a small
// imem responder plus a decode-side monitor.
module tb_ysyx_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h8000_0000;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  typedef struct {
    logic [31:0] inst;
    logic [31:0] pc;
    logic        err;
  } exp_t;

  logic clk;
  logic rst_n;

  ysyx_ifu_fetch_if bus ();

  ysyx_ifu_fetch dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        exp_q[$];
  int          n_chk = 0;
  int          n_pass = 0;
  int          n_acc = 0;
  int          rsp_delay = 0;
  logic        err_mode = 1'b0;
  logic [31:0] last_addr = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [31:0] mem_word(
    input logic [31:0] a
  );
    if (a == RST_PC) return 32'h0010_0093;
    return a ^ 32'h00a5_0013;
  endfunction

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s got=%h exp=%h",
                  tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // imem model: one response per accepted request
  initial begin
    logic [31:0] a;
    logic        e;
    bus.imem_rsp_valid = 1'b0;
    bus.imem_rsp_data  = '0;
    bus.imem_rsp_err   = 1'b0;
    forever begin
      @(posedge clk);
      if (bus.imem_req_valid && bus.imem_req_ready) begin
        a = bus.imem_req_addr;
        e = err_mode;
        n_acc++;
        last_addr = a;
        repeat (rsp_delay) @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b1;
        bus.imem_rsp_data  = mem_word(a);
        bus.imem_rsp_err   = e;
        @(posedge clk);
        #1;
        bus.imem_rsp_valid = 1'b0;
      end
    end
  end

  // decode side: pop on handshake, check hold while stalled
  initial begin
    exp_t        e;
    logic        held;
    logic [31:0] h_inst, h_pc;
    logic        h_err;
    held = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        held = 1'b0;
      end else begin
        if (held) begin
          chk("hold_v", {31'd0, bus.inst_valid}, 1);
          chk("hold_inst", bus.inst, h_inst);
          chk("hold_pc", bus.inst_pc, h_pc);
          chk("hold_err", {31'd0, bus.inst_err},
              {31'd0, h_err});
        end
        held = 1'b0;
        if (bus.inst_valid) begin
          if (bus.inst_ready) begin
            if (exp_q.size() == 0) begin
              chk("unexp_inst", bus.inst_pc, '1);
            end else begin
              e = exp_q.pop_front();
              chk("inst", bus.inst, e.inst);
              chk("inst_pc", bus.inst_pc, e.pc);
              chk("inst_err", {31'd0, bus.inst_err},
                  {31'd0, e.err});
            end
          end else begin
            held   = 1'b1;
            h_inst = bus.inst;
            h_pc   = bus.inst_pc;
            h_err  = bus.inst_err;
          end
        end
      end
    end
  end

  task automatic wait_req(input string tag);
    int k = 0;
    while (!bus.imem_req_valid && k < 40) begin
      tick();
      k++;
    end
    if (!bus.imem_req_valid) chk(tag, 0, 1);
  endtask

  task automatic wait_iv(input string tag);
    int k = 0;
    while (!bus.inst_valid && k < 40) begin
      tick();
      k++;
    end
    if (!bus.inst_valid) chk(tag, 0, 1);
  endtask

  task automatic wait_deliv(input string tag);
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) chk(tag, exp_q.size(), 0);
  endtask

  task automatic next_pc(input logic [31:0] p);
    bus.pc_upd_valid = 1'b1;
    bus.pc_upd       = p;
    tick();
    bus.pc_upd_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog n_chk=%0d", n_chk);
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int base;
    logic [31:0] a0;

    rst_n              = 1'b0;
    bus.imem_req_ready = 1'b1;
    bus.inst_ready     = 1'b1;
    bus.pc_upd_valid   = 1'b0;
    bus.pc_upd         = '0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;

    repeat (3) tick();
    chk("rst_req_v", {31'd0, bus.imem_req_valid}, 0);
    chk("rst_inst_v", {31'd0, bus.inst_valid}, 0);

    // first fetch and latency after accept
    exp_q.push_back('{32'h0010_0093, RST_PC, 1'b0});
    rst_n = 1'b1;
    wait_req("to_req1");
    chk("addr1", bus.imem_req_addr, RST_PC);
    k = 0;
    while (!bus.inst_valid && k < 10) begin
      tick();
      k++;
    end
    chk("latency", k, 2);
    wait_deliv("to_deliv1");

    // nothing fetched until the next pc arrives
    repeat (3) begin
      tick();
      chk("wait_pc_idle", {31'd0, bus.imem_req_valid}, 0);
    end

    // decode stalls for 5 cycles
    bus.inst_ready = 1'b0;
    exp_q.push_back('{mem_word(32'h8000_0004),
                      32'h8000_0004, 1'b0});
    next_pc(32'h8000_0004);
    wait_req("to_req2");
    chk("addr2", bus.imem_req_addr, 32'h8000_0004);
    wait_iv("to_iv2");
    repeat (5) tick();
    bus.inst_ready = 1'b1;
    wait_deliv("to_deliv2");

    // memory not ready for 3 cycles
    bus.imem_req_ready = 1'b0;
    exp_q.push_back('{mem_word(32'h8000_0008),
                      32'h8000_0008, 1'b0});
    next_pc(32'h8000_0008);
    wait_req("to_req3");
    a0 = bus.imem_req_addr;
    chk("addr3", a0, 32'h8000_0008);
    repeat (3) begin
      tick();
      chk("bp_valid", {31'd0, bus.imem_req_valid}, 1);
      chk("bp_addr", bus.imem_req_addr, a0);
    end
    bus.imem_req_ready = 1'b1;
    wait_deliv("to_deliv3");

    // access fault
    err_mode = 1'b1;
    exp_q.push_back('{NOP, 32'h8000_000c, 1'b1});
    next_pc(32'h8000_000c);
    wait_deliv("to_deliv4");
    err_mode = 1'b0;

    // misaligned pc never reaches memory
    base = n_acc;
    exp_q.push_back('{NOP, 32'h8000_0002, 1'b1});
    next_pc(32'h8000_0002);
    wait_deliv("to_deliv5");
    chk("mis_noreq", n_acc, base);

    // redirect while the response is still pending
    rsp_delay = 2;
    base = n_acc;
    next_pc(32'h8000_0020);
    k = 0;
    while (n_acc == base && k < 20) begin
      tick();
      k++;
    end
    chk("redir_acc", n_acc, base + 1);
    exp_q.push_back('{mem_word(32'h8000_0100),
                      32'h8000_0100, 1'b0});
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h8000_0100;
    tick();
    bus.redirect_valid = 1'b0;
    rsp_delay = 0;
    chk("drop_hold1", {31'd0, bus.imem_req_valid}, 0);
    tick();
    chk("drop_hold2", {31'd0, bus.imem_req_valid}, 0);
    wait_deliv("to_deliv6");
    chk("redir_addr", last_addr, 32'h8000_0100);
    chk("redir_nacc", n_acc, base + 2);

    // async reset while delivering
    bus.inst_ready = 1'b0;
    exp_q.push_back('{mem_word(32'h8000_0104),
                      32'h8000_0104, 1'b0});
    next_pc(32'h8000_0104);
    wait_iv("to_iv7");
    #1;
    rst_n = 1'b0;
    #1;
    chk("rst_async_v", {31'd0, bus.inst_valid}, 0);
    exp_q.delete();
    repeat (2) tick();
    chk("rst_req_v2", {31'd0, bus.imem_req_valid}, 0);
    bus.inst_ready = 1'b1;
    exp_q.push_back('{32'h0010_0093, RST_PC, 1'b0});
    rst_n = 1'b1;
    wait_deliv("to_deliv8");
    chk("rst_addr", last_addr, RST_PC);

    repeat (3) tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
